// File: rtl/acc_csr_bank.sv
// Accelerator CSR bank: control words, command pulses, sticky events with IRQ, sampled status.
// Single-cycle accept (gnt = req); response after READ_LATENCY cycles.
module acc_csr_bank #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int N_CTRL_WORDS    = 4,
  parameter int N_STAT_WORDS    = 2,
  parameter int N_EVT           = 8,
  parameter int READ_LATENCY    = 1,
  parameter int REGISTER_STATUS = 1
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic                                   req,
  input  logic                                   we,
  input  logic [ADDR_WIDTH-1:0]                  addr,
  input  logic [DATA_WIDTH/8-1:0]                be,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  output logic                                   gnt,
  output logic                                   rvalid,
  output logic [DATA_WIDTH-1:0]                  rdata,
  output logic                                   err,
  output logic [N_CTRL_WORDS-1:0][DATA_WIDTH-1:0] ctrl_vec,
  input  logic [(N_STAT_WORDS > 0 ? N_STAT_WORDS : 1)-1:0][DATA_WIDTH-1:0] stat_vec,
  input  logic                                   stat_en,
  input  logic                                   busy_i,
  input  logic [N_EVT-1:0]                       evt_i,
  output logic                                   start_o,
  output logic                                   soft_rst_o,
  output logic                                   irq_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int EW = N_EVT + 1;
  localparam int NS = (N_STAT_WORDS > 0) ? N_STAT_WORDS : 1;
  localparam logic [ADDR_WIDTH-1:0] A_CMD = ADDR_WIDTH'(N_CTRL_WORDS);
  localparam logic [ADDR_WIDTH-1:0] A_EVS = ADDR_WIDTH'(N_CTRL_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] A_EEN = ADDR_WIDTH'(N_CTRL_WORDS + 2);
  localparam logic [ADDR_WIDTH-1:0] A_ST0 = ADDR_WIDTH'(N_CTRL_WORDS + 3);
  localparam logic [ADDR_WIDTH-1:0] A_END = ADDR_WIDTH'(N_CTRL_WORDS + 3 + N_STAT_WORDS);

  logic [N_CTRL_WORDS-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [EW-1:0]                 evt_stat_q, evt_stat_d, evt_en_q;
  logic [NS-1:0][DATA_WIDTH-1:0] stat_rd;
  logic [DATA_WIDTH-1:0]         bmask, wmask, rd_c;
  logic is_ctrl, is_cmd, is_evs, is_een, is_stat, err_c, wr_ok, cmd_wr;
  logic soft_c, start_c, ovr_c, start_q, soft_q, irq_q;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < NB; b++) bmask[b*8 +: 8] = {8{be[b]}};
  end
  assign wmask = wdata & bmask;

  assign is_ctrl = addr < A_CMD;
  assign is_cmd  = addr == A_CMD;
  assign is_evs  = addr == A_EVS;
  assign is_een  = addr == A_EEN;
  assign is_stat = (addr >= A_ST0) && (addr < A_END);
  assign err_c   = (addr >= A_END) | (we & is_stat) | (we & is_ctrl & busy_i);
  assign wr_ok   = req & we & ~err_c;
  assign cmd_wr  = wr_ok & is_cmd & be[0];
  // Soft reset outranks start; a start against a busy engine becomes an overrun event.
  assign soft_c  = cmd_wr & wdata[1];
  assign start_c = cmd_wr & wdata[0] & ~wdata[1] & ~busy_i;
  assign ovr_c   = cmd_wr & wdata[0] & ~wdata[1] & busy_i;
  assign gnt     = req;

  always_comb begin
    rd_c = '0;
    for (int i = 0; i < N_CTRL_WORDS; i++)
      if (addr == ADDR_WIDTH'(i)) rd_c = ctrl_q[i];
    if (is_evs) rd_c = DATA_WIDTH'(evt_stat_q);
    if (is_een) rd_c = DATA_WIDTH'(evt_en_q);
    for (int i = 0; i < N_STAT_WORDS; i++)
      if (addr == ADDR_WIDTH'(N_CTRL_WORDS + 3 + i)) rd_c = stat_rd[i];
    if (we || err_c) rd_c = '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_q <= '0;
    end else if (soft_c) begin
      ctrl_q <= '0;
    end else if (wr_ok && is_ctrl) begin
      for (int i = 0; i < N_CTRL_WORDS; i++)
        if (addr == ADDR_WIDTH'(i)) ctrl_q[i] <= (ctrl_q[i] & ~bmask) | wmask;
    end
  end
  assign ctrl_vec = ctrl_q;

  // Clear first, then set, so a same-cycle event survives its write-1-to-clear.
  always_comb begin
    evt_stat_d = evt_stat_q;
    if (wr_ok && is_evs) evt_stat_d = evt_stat_d & ~wmask[EW-1:0];
    evt_stat_d = evt_stat_d | {ovr_c, evt_i};
    if (soft_c) evt_stat_d = '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      evt_stat_q <= '0;
      evt_en_q   <= '0;
      start_q    <= 1'b0;
      soft_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      evt_stat_q <= evt_stat_d;
      if (wr_ok && is_een) evt_en_q <= (evt_en_q & ~bmask[EW-1:0]) | wmask[EW-1:0];
      start_q    <= start_c;
      soft_q     <= soft_c;
      irq_q      <= |(evt_stat_q & evt_en_q);
    end
  end
  assign start_o    = start_q;
  assign soft_rst_o = soft_q;
  assign irq_o      = irq_q;

  if (REGISTER_STATUS != 0) begin : g_stat_reg
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)      stat_rd <= '0;
      else if (stat_en) stat_rd <= stat_vec;
    end
  end else begin : g_stat_pass
    assign stat_rd = stat_vec;
  end

  if (READ_LATENCY == 0) begin : g_resp_comb
    assign rvalid = req;
    assign rdata  = req ? rd_c : '0;
    assign err    = req & err_c;
  end else begin : g_resp_reg
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        rvalid <= 1'b0;
        rdata  <= '0;
        err    <= 1'b0;
      end else begin
        rvalid <= req;
        err    <= req & err_c;
        if (req) rdata <= rd_c;
      end
    end
  end
endmodule

// File: tb/tb_acc_csr_bank.sv
// Directed bench for acc_csr_bank at default parameters (C=4, 2 status words, 8 events, latency 1).
module tb_acc_csr_bank;
  localparam int AW = 32, DW = 32, NC = 4, NS = 2, NE = 8;
  localparam int A_CMD = NC, A_EVS = NC + 1, A_EEN = NC + 2, A_ST0 = NC + 3;

  logic clk = 1'b0, arst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    be = '0;
  logic [DW-1:0] wdata = '0;
  logic gnt, rvalid, err, start_o, soft_rst_o, irq_o;
  logic [DW-1:0] rdata;
  logic [NC-1:0][DW-1:0] ctrl_vec;
  logic [NS-1:0][DW-1:0] stat_vec = '0;
  logic stat_en = 1'b0, busy_i = 1'b0;
  logic [NE-1:0] evt_i = '0;

  int n_vec = 0, n_err = 0;
  logic pre_vld, r_vld, r_err, r_gnt;
  logic [DW-1:0] r_dat;

  always #5 clk = ~clk;

  acc_csr_bank dut (
    .clk(clk), .arst_n(arst_n), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .ctrl_vec(ctrl_vec),
    .stat_vec(stat_vec), .stat_en(stat_en), .busy_i(busy_i), .evt_i(evt_i),
    .start_o(start_o), .soft_rst_o(soft_rst_o), .irq_o(irq_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1 with the response captured.
  task automatic bus(input logic w, input int a, input logic [3:0] b, input logic [DW-1:0] d);
    req = 1'b1; we = w; addr = AW'(a); be = b; wdata = d;
    #1;
    pre_vld = rvalid;
    r_gnt   = gnt;
    @(posedge clk); #1;
    r_vld = rvalid; r_dat = rdata; r_err = err;
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #3;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_pulses", {start_o, soft_rst_o, irq_o}, 0);
    chk("rst_ctrl", |ctrl_vec, 0);
    @(negedge clk); arst_n = 1'b1;
    idle();

    // Byte-enabled CTRL write and readback
    bus(1, 1, 4'b0101, 32'hDEADBEEF);
    chk("gnt", r_gnt, 1);
    chk("wr_rvalid", r_vld, 1);
    chk("wr_rdata", r_dat, 0);
    chk("wr_err", r_err, 0);
    chk("ctrl1_vec", ctrl_vec[1], 32'h00AD00EF);
    idle();
    chk("rvalid_one_cycle", rvalid, 0);
    bus(0, 1, 4'hF, 0);
    chk("rd_pre_vld", pre_vld, 0);
    chk("rd_rvalid", r_vld, 1);
    chk("rd_ctrl1", r_dat, 32'h00AD00EF);
    chk("rd_err", r_err, 0);
    idle();
    chk("rdata_hold", rdata, 32'h00AD00EF);
    chk("rvalid_drop", rvalid, 0);

    // CTRL lock and start overrun while busy
    bus(1, 0, 4'hF, 32'h5);
    busy_i = 1'b1;
    bus(1, 0, 4'hF, 32'h1);
    chk("busy_ctrl_err", r_err, 1);
    chk("busy_ctrl_kept", ctrl_vec[0], 32'h5);
    bus(1, A_CMD, 4'hF, 32'h1);
    chk("busy_cmd_err", r_err, 0);
    chk("busy_no_start", start_o, 0);
    bus(0, A_EVS, 4'hF, 0);
    chk("overrun_bit", r_dat, 32'h100);
    busy_i = 1'b0;
    bus(1, A_CMD, 4'hF, 32'h1);
    chk("start_pulse", start_o, 1);
    idle();
    chk("start_one_cycle", start_o, 0);
    bus(1, A_EVS, 4'hF, 32'h100);
    bus(0, A_EVS, 4'hF, 0);
    chk("overrun_cleared", r_dat, 0);

    // Enable masking of upper bits, event set, IRQ, W1C vs event race
    bus(1, A_EEN, 4'hF, 32'hFFFFFFFF);
    bus(0, A_EEN, 4'hF, 0);
    chk("evt_en_mask", r_dat, 32'h1FF);
    bus(1, A_EEN, 4'hF, 32'h1);
    evt_i = 8'h01;
    idle();
    evt_i = 8'h00;
    chk("irq_not_yet", irq_o, 0);
    idle();
    chk("irq_set", irq_o, 1);
    evt_i = 8'h01;
    bus(1, A_EVS, 4'hF, 32'h1);
    evt_i = 8'h00;
    bus(0, A_EVS, 4'hF, 0);
    chk("set_beats_clear", r_dat, 32'h1);
    bus(1, A_EVS, 4'hF, 32'h1);
    chk("irq_lag", irq_o, 1);
    idle();
    chk("irq_cleared", irq_o, 0);

    // Soft reset with start in the same command
    bus(1, 2, 4'hF, 32'h12345678);
    evt_i = 8'h08;
    idle();
    evt_i = 8'h00;
    bus(0, A_EVS, 4'hF, 0);
    chk("evt3_sticky", r_dat, 32'h08);
    bus(1, A_CMD, 4'hF, 32'h3);
    chk("soft_pulse", soft_rst_o, 1);
    chk("soft_no_start", start_o, 0);
    chk("soft_ctrl0", ctrl_vec[0], 0);
    chk("soft_ctrl1", ctrl_vec[1], 0);
    chk("soft_ctrl2", ctrl_vec[2], 0);
    idle();
    chk("soft_one_cycle", soft_rst_o, 0);
    bus(0, A_EEN, 4'hF, 0);
    chk("soft_keeps_en", r_dat, 32'h1);
    bus(0, A_EVS, 4'hF, 0);
    chk("soft_clears_evt", r_dat, 0);

    // Out-of-map, STAT write, status sampling, CMD readback
    bus(0, A_ST0 + NS, 4'hF, 0);
    chk("oob_err", r_err, 1);
    chk("oob_rdata", r_dat, 0);
    chk("oob_rvalid", r_vld, 1);
    bus(1, A_ST0, 4'hF, 32'hFFFF);
    chk("stat_wr_err", r_err, 1);
    stat_vec[0] = 32'h1234;
    stat_en = 1'b1;
    idle();
    stat_en = 1'b0;
    stat_vec[0] = 32'hFFFF;
    bus(0, A_ST0, 4'hF, 0);
    chk("stat_sampled", r_dat, 32'h1234);
    chk("stat_rd_err", r_err, 0);
    bus(0, A_CMD, 4'hF, 0);
    chk("cmd_reads_0", r_dat, 0);

    // Reset with a read response in flight
    bus(1, 3, 4'hF, 32'hA5);
    chk("ctrl3_set", ctrl_vec[3], 32'hA5);
    req = 1'b1; we = 1'b0; addr = AW'(A_EEN); be = 4'hF;
    @(negedge clk);
    arst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_outs", {err, start_o, soft_rst_o, irq_o}, 0);
    chk("arst_ctrl", |ctrl_vec, 0);
    idle();
    chk("arst_no_resp", rvalid, 0);
    @(negedge clk); arst_n = 1'b1;
    idle();
    chk("post_rst_rvalid0", rvalid, 0);
    idle();
    chk("post_rst_rvalid1", rvalid, 0);
    bus(0, A_EEN, 4'hF, 0);
    chk("post_rst_en", r_dat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/acc_csr_bank.md
ACC_CSR_BANK -- requirements
Module: acc_csr_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register width, multiple of 8, at least 16.
REQ-003 SHALL have parameter N_CTRL_WORDS, default 4: read-write control words, at least 1.
REQ-004 SHALL have parameter N_STAT_WORDS, default 2: read-only status words, at least 0.
REQ-005 SHALL have parameter N_EVT, default 8: event/IRQ sources, 1 to DATA_WIDTH-1.
REQ-006 SHALL have parameter READ_LATENCY, default 1: response latency, 0 or 1.
REQ-007 SHALL have parameter REGISTER_STATUS, default 1: sample stat_vec on stat_en when 1; pass it through when 0.
REQ-008 SHALL have these ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- req  in  1  access request.
- we  in  1  write when 1.
- addr  in  ADDR_WIDTH  word address.
- be  in  DATA_WIDTH/8  byte enables.
- wdata  in  DATA_WIDTH  write data.
- gnt  out  1  request accepted.
- rvalid  out  1  response valid.
- rdata  out  DATA_WIDTH  read data.
- err  out  1  error response, qualified by rvalid.
- ctrl_vec  out  N_CTRL_WORDS x DATA_WIDTH  control words.
- stat_vec  in  N_STAT_WORDS x DATA_WIDTH  status words.
- stat_en  in  1  status sample strobe.
- busy_i  in  1  accelerator busy.
- evt_i  in  N_EVT  event pulses.
- start_o  out  1  start pulse.
- soft_rst_o  out  1  soft-reset pulse.
- irq_o  out  1  interrupt.

Function
REQ-009 SHALL use this word map, with C = N_CTRL_WORDS:
- 0..C-1: CTRL, read-write.
- C: CMD, write-only, reads 0.
- C+1: EVT_STAT, write-1-to-clear.
- C+2: EVT_EN, read-write.
- C+3..C+2+N_STAT_WORDS: STAT, read-only.
REQ-010 SHALL drive gnt equal to req, with no backpressure; an access is accepted in a cycle where req is 1.
REQ-011 SHALL assert rvalid for exactly one cycle per accepted access, reads and writes alike: in the same cycle when READ_LATENCY = 0, and on the next cycle when READ_LATENCY = 1.
REQ-012 SHALL drive rdata to 0 for writes and error responses; rdata SHALL hold its value while rvalid is 0 when READ_LATENCY = 1.
REQ-013 SHALL apply writes byte-wise per be, on the clock edge of acceptance; be = 0 is a legal no-op.
REQ-014 SHALL respond with err = 1 and no state change for any of:
- an address beyond the map;
- a write to STAT;
- a write to CTRL while busy_i = 1 (CTRL is locked while busy).
REQ-015 SHALL, on a CMD write with be[0] = 1, wdata[0] = 1 and busy_i = 0, pulse start_o for exactly one cycle, the cycle after acceptance.
REQ-016 SHALL treat a CMD start while busy_i = 1 as follows: no start_o, err = 0, and EVT_STAT bit N_EVT (the overrun bit) set.
REQ-017 SHALL, on a CMD write with wdata[1] = 1 and be[0] = 1, on the next edge:
- clear CTRL and EVT_STAT;
- pulse soft_rst_o for one cycle;
- leave EVT_EN unchanged.
REQ-018 SHALL give soft reset priority over start when both bits are written together; start_o stays 0.
REQ-019 SHALL set EVT_STAT[i] sticky when evt_i[i] = 1 on a clock edge.
REQ-020 SHALL give set priority over clear when an event and a write-1-to-clear hit the same bit in the same cycle.
REQ-021 SHALL read EVT_STAT bits above N_EVT and EVT_EN bits above N_EVT as 0, and ignore writes to them.
REQ-022 SHALL register irq_o as the OR-reduction of (EVT_STAT AND EVT_EN), one cycle after the contributing state changes.
REQ-023 SHALL capture all stat_vec words together on an edge with stat_en = 1 when REGISTER_STATUS = 1; otherwise STAT reads stat_vec combinationally.
REQ-024 SHALL, on a read and a CTRL or EVT_STAT update in the same cycle, return the pre-update value.
REQ-025 SHALL drive ctrl_vec directly from the CTRL registers.

Reset
REQ-026 SHALL, on arst_n = 0, asynchronously clear to 0: CTRL, EVT_STAT, EVT_EN, sampled STAT, rvalid, rdata, err, start_o, soft_rst_o and irq_o.
REQ-027 SHALL discard a response pending at reset; rvalid stays 0 after release until a new access is accepted.

Verification
REQ-028 SHALL cover: write CTRL[1] = 0xDEADBEEF with be = 0b0101, then read it -> rdata = 0x00AD00EF, err = 0, rvalid 1 cycle after acceptance (READ_LATENCY = 1).
REQ-029 SHALL cover: busy_i = 1, write CTRL[0] = 0x1, and CMD = 0x1 -> CTRL write gives err = 1 with CTRL[0] unchanged; CMD write gives no start_o and EVT_STAT bit N_EVT = 1.
REQ-030 SHALL cover: EVT_EN = 0x01, pulse evt_i[0] -> irq_o = 1 next cycle; W1C 0x01 in the same cycle as evt_i[0] = 1 -> bit stays 1; W1C alone -> irq_o = 0 one cycle later.
REQ-031 SHALL cover: write CMD = 0x3 with busy_i = 0 -> soft_rst_o 1 cycle, start_o stays 0, CTRL all 0, EVT_EN preserved.
REQ-032 SHALL cover: read address C+3+N_STAT_WORDS -> err = 1, rdata = 0; stat_en pulse with stat_vec[0] = 0x1234 -> a later read of C+3 returns 0x1234 despite stat_vec changing.
REQ-033 SHALL cover: assert arst_n = 0 in the cycle after a read is accepted -> rvalid never asserts, all outputs 0.
